cu_sequencer: RTL and testbench
===============================

Name: cu_sequencer

Overview:
Control-unit state sequencer that sits directly upstream of the per-class decoders (immediate, register, memory, branch).
- Owns the instruction register, the 4-bit execute state and the NZCV status register.
- Feeds IR, state and status to the decoders.
- Takes back the selected decoder's next-state and control word, and emits the final control word to the datapath, overriding it during fetch, stall and reset.

Parameters:
CUL, 36, MSB index of control word; word width CUL+1.
MAX_EX, 4, max execute cycles per instruction before forced return to fetch (2..15).

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  synchronous, active-low reset.
instr_in  input  32  instruction from instruction memory.
instr_valid  input  1  instr_in valid this cycle.
stall  input  1  datapath/memory stall request.
ns_in  input  4  next state from selected decoder.
cw_in  input  CUL+1  control word from selected decoder.
status_in  input  4  ALU flags {V,C,N,Z}.
instr_req  output  1  fetch request to instruction memory.
IR  output  32  instruction register.
state  output  4  current state to decoders.
status  output  4  registered flags.
controlWord  output  CUL+1  control word to datapath.
fault  output  1  sticky sequencing fault.
instr_count  output  32  retired-instruction count.

Behaviour:
- States: FETCH=4'b0000, EX0=4'b0001, EX1=4'b0010, EX2=4'b0011. Any other ns_in value is illegal.
- Control word field map, LSB up:
  - PC_FS[1:0], PC_sel[2], data_tri_sel[4:3], add_tri_sel[5], size[7:6], status_load[8], IR_load[9], mem_write_en[10], B_Sel[11], mem_cs[13:12], C0[14], w_reg[15], DA[20:16], SB[25:21], SA[30:26], FS[35:31].
  - Bits above 35 are zero.
- NOP word: all zero (PC_FS=00 holds PC; no writes).
- FETCH word: NOP with IR_load=1.
- Reset (reset low at edge): state=FETCH, IR=0, status=0, fault=0, ex_cnt=0, instr_count=0.
  - While reset is low: controlWord=NOP, instr_req=0 (combinational override).
  - Reset mid-instruction abandons it; no retire count.
- FETCH:
  - instr_req=1.
  - If instr_valid & ~stall: controlWord=FETCH word; next edge IR<=instr_in, state<=EX0, ex_cnt<=1.
  - Else controlWord=NOP; hold.
- EXn, no stall:
  - controlWord=cw_in unchanged; instr_req=0.
  - Edge: if cw_in[8], status<=status_in.
  - ns_in legal and nonzero: state<=ns_in, ex_cnt++.
  - ns_in=FETCH: state<=FETCH, instr_count++ (wraps at 2^32).
  - ns_in illegal: state<=FETCH, fault<=1, no retire count.
- Watchdog: in EXn with ex_cnt==MAX_EX and ns_in != FETCH: force state<=FETCH, fault<=1, no retire count. Watchdog takes precedence over legal ns_in.
- Stall (any state):
  - controlWord=NOP; state, IR, status, ex_cnt, instr_count frozen; instr_req held at its unstalled value.
  - Stall overrides instr_valid; the instruction is not captured.
- Latency: fetch-to-first-execute is 1 cycle. A single-cycle instruction occupies 2 cycles (FETCH, EX0).
- fault clears only on reset.

Optional Feature:
CU_TRACE_EN:
- Defined: adds output trace_valid (1) and trace_ir (32).
  - trace_valid pulses one cycle, registered, on the cycle after each retire.
  - trace_ir holds the retired IR until the next retire.
  - Both reset to 0.
- Undefined: ports absent; no extra logic.

Test Plan:
- Reset held low 2 cycles, then released with instr_valid=0 -> state=0000, controlWord=0, instr_req=0 during reset; instr_req=1 after release; IR=0.
- instr_valid=0 for 3 cycles, then instr_in=32'h91000421 with valid=1 -> IR_load=1 only on the valid cycle; IR=32'h91000421, state=0001 next cycle.
- In EX0, ns_in=0000, cw_in=37'h0000000101 -> controlWord=cw_in; status<=status_in (4'b0110); state=0000; instr_count=1.
- Two-cycle op: ns_in=0010 in EX0, then 0000 in EX1 -> states 0001,0010,0000; instr_count +1 only once.
- stall=1 for 2 cycles in EX1 with ns_in=0000 -> controlWord=0, state stays 0010; retires on the cycle after stall drops.
- ns_in=4'b0111 -> state=0000, fault=1, instr_count unchanged. Separately, with MAX_EX=4 and ns_in looping 0011 -> forced FETCH after 4th EX cycle, fault=1.

Source files
------------

// File: rtl/cu_sequencer.sv
// cu_sequencer
//   Control-unit state sequencer sitting upstream of the per-class decoders.
//   It owns the instruction register, the execute state and the NZCV status
//   register. It hands IR/state/status to the decoders, takes back the selected
//   decoder's next state and control word, and drives the final control word to
//   the datapath. During reset, stall and fetch, it overrides that word.
//
// Parameters
//   CUL     MSB index of the control word (word width CUL+1)
//   MAX_EX  execute cycles allowed per instruction before a forced fetch (2..15)
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-low reset
//   instr_in     in   [31:0] instruction from instruction memory
//   instr_valid  in   instr_in valid this cycle
//   stall        in   datapath/memory stall request
//   ns_in        in   [3:0] next state from selected decoder
//   cw_in        in   [CUL:0] control word from selected decoder
//   status_in    in   [3:0] ALU flags {V,C,N,Z}
//   instr_req    out  fetch request to instruction memory
//   IR           out  [31:0] instruction register
//   state        out  [3:0] current state to decoders
//   status       out  [3:0] registered flags
//   controlWord  out  [CUL:0] control word to datapath
//   fault        out  sticky sequencing fault
//   instr_count  out  [31:0] retired-instruction count
//
// Optional feature (macro CU_TRACE_EN)
//   trace_valid  out  one-cycle registered pulse after each retire
//   trace_ir     out  [31:0] IR of the most recently retired instruction

module cu_sequencer #(
  parameter int CUL    = 36,
  parameter int MAX_EX = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [31:0]   instr_in,
  input  logic          instr_valid,
  input  logic          stall,
  input  logic [3:0]    ns_in,
  input  logic [CUL:0]  cw_in,
  input  logic [3:0]    status_in,
  output logic          instr_req,
  output logic [31:0]   IR,
  output logic [3:0]    state,
  output logic [3:0]    status,
  output logic [CUL:0]  controlWord,
  output logic          fault,
`ifdef CU_TRACE_EN
  output logic          trace_valid,
  output logic [31:0]   trace_ir,
`endif
  output logic [31:0]   instr_count
);

  typedef enum logic [3:0] {
    ST_FETCH = 4'b0000,
    ST_EX0   = 4'b0001,
    ST_EX1   = 4'b0010,
    ST_EX2   = 4'b0011
  } state_t;

  localparam logic [CUL:0] CW_NOP   = '0;
  localparam logic [CUL:0] CW_FETCH = (CUL+1)'(1) << 9;  // IR_load only

  state_t       r_state, w_state_nxt;
  logic [31:0]  r_ir, w_ir_nxt;
  logic [3:0]   r_status, w_status_nxt;
  logic         r_fault, w_fault_nxt;
  logic [3:0]   r_ex_cnt, w_ex_cnt_nxt;
  logic [31:0]  r_instr_count, w_instr_count_nxt;
  logic         w_retire;
  logic         w_ns_legal;
  logic         w_watchdog;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= ST_FETCH;
      r_ir          <= '0;
      r_status      <= '0;
      r_fault       <= 1'b0;
      r_ex_cnt      <= '0;
      r_instr_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_ir          <= w_ir_nxt;
      r_status      <= w_status_nxt;
      r_fault       <= w_fault_nxt;
      r_ex_cnt      <= w_ex_cnt_nxt;
      r_instr_count <= w_instr_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_ir_nxt          = r_ir;
    w_status_nxt      = r_status;
    w_fault_nxt       = r_fault;
    w_ex_cnt_nxt      = r_ex_cnt;
    w_instr_count_nxt = r_instr_count;
    w_retire          = 1'b0;
    instr_req         = 1'b0;
    controlWord       = CW_NOP;
    w_ns_legal        = (ns_in <= 4'(ST_EX2));
    // Watchdog only matters when the decoder is not already returning to fetch.
    w_watchdog        = (r_ex_cnt == 4'(MAX_EX)) && (ns_in != 4'(ST_FETCH));

    case (r_state)
      ST_FETCH: begin
        // instr_req ignores stall so memory sees a steady request.
        instr_req = 1'b1;
        if (instr_valid && !stall) begin
          controlWord  = CW_FETCH;
          w_ir_nxt     = instr_in;
          w_state_nxt  = ST_EX0;
          w_ex_cnt_nxt = 4'd1;
        end
      end
      default: begin
        if (!stall) begin
          controlWord = cw_in;
          if (cw_in[8]) w_status_nxt = status_in;
          if (ns_in == 4'(ST_FETCH)) begin
            w_state_nxt       = ST_FETCH;
            w_ex_cnt_nxt      = '0;
            w_instr_count_nxt = r_instr_count + 32'd1;
            w_retire          = 1'b1;
          end else if (w_watchdog || !w_ns_legal) begin
            w_state_nxt  = ST_FETCH;
            w_ex_cnt_nxt = '0;
            w_fault_nxt  = 1'b1;
          end else begin
            w_state_nxt  = state_t'(ns_in);
            w_ex_cnt_nxt = r_ex_cnt + 4'd1;
          end
        end
      end
    endcase

    // Reset overrides everything the datapath or memory could act on.
    if (!reset) begin
      instr_req   = 1'b0;
      controlWord = CW_NOP;
    end
  end

  assign IR          = r_ir;
  assign state       = r_state;
  assign status      = r_status;
  assign fault       = r_fault;
  assign instr_count = r_instr_count;

`ifdef CU_TRACE_EN
  logic        r_trace_valid;
  logic [31:0] r_trace_ir;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_trace_valid <= 1'b0;
      r_trace_ir    <= '0;
    end else begin
      r_trace_valid <= w_retire;
      if (w_retire) r_trace_ir <= r_ir;
    end
  end

  assign trace_valid = r_trace_valid;
  assign trace_ir    = r_trace_ir;
`endif

endmodule

// File: tb/tb_cu_sequencer.sv
module tb_cu_sequencer;

  localparam int CUL = 36;

  logic          clock = 1'b0;
  logic          reset;
  logic [31:0]   instr_in;
  logic          instr_valid;
  logic          stall;
  logic [3:0]    ns_in;
  logic [CUL:0]  cw_in;
  logic [3:0]    status_in;
  logic          instr_req;
  logic [31:0]   IR;
  logic [3:0]    state;
  logic [3:0]    status;
  logic [CUL:0]  controlWord;
  logic          fault;
  logic [31:0]   instr_count;
`ifdef CU_TRACE_EN
  logic          trace_valid;
  logic [31:0]   trace_ir;
`endif

  int n_total = 0;
  int n_bad   = 0;

  cu_sequencer #(.CUL(CUL), .MAX_EX(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .stall       (stall),
    .ns_in       (ns_in),
    .cw_in       (cw_in),
    .status_in   (status_in),
    .instr_req   (instr_req),
    .IR          (IR),
    .state       (state),
    .status      (status),
    .controlWord (controlWord),
    .fault       (fault),
`ifdef CU_TRACE_EN
    .trace_valid (trace_valid),
    .trace_ir    (trace_ir),
`endif
    .instr_count (instr_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; instr_in = '0; instr_valid = 1'b0; stall = 1'b0;
    ns_in = '0; cw_in = '0; status_in = '0;

    // Reset held two cycles
    tick(); tick();
    check("rst_state", 64'(state), 64'h0);
    check("rst_cw",    64'(controlWord), 64'h0);
    check("rst_req",   64'(instr_req), 64'h0);
    check("rst_ir",    64'(IR), 64'h0);
    check("rst_stat",  64'(status), 64'h0);
    check("rst_fault", 64'(fault), 64'h0);
    check("rst_cnt",   64'(instr_count), 64'h0);

    reset = 1'b1; #1;
    check("rel_req", 64'(instr_req), 64'h1);
    check("rel_cw",  64'(controlWord), 64'h0);

    // Idle fetch cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_state", 64'(state), 64'h0);
      check("idle_cw",    64'(controlWord), 64'h0);
    end

    // Capture first instruction
    instr_in = 32'h91000421; instr_valid = 1'b1; #1;
    check("fetch_cw", 64'(controlWord), 64'h200);
    tick(); instr_valid = 1'b0;
    check("fetch_ir",    64'(IR), 64'h91000421);
    check("fetch_state", 64'(state), 64'h1);

    // Single-cycle op with status load
    ns_in = 4'b0000; cw_in = 37'h0000000101; status_in = 4'b0110; #1;
    check("ex0_cw",  64'(controlWord), 64'h101);
    check("ex0_req", 64'(instr_req), 64'h0);
    tick();
    check("ret1_stat",  64'(status), 64'h6);
    check("ret1_state", 64'(state), 64'h0);
    check("ret1_cnt",   64'(instr_count), 64'h1);

    // Two-cycle op, stalled in EX1
    instr_in = 32'h0000000A; instr_valid = 1'b1;
    tick(); instr_valid = 1'b0;
    check("two_s0", 64'(state), 64'h1);
    ns_in = 4'b0010; cw_in = '0; status_in = 4'b1111;
    tick();
    check("two_s1",   64'(state), 64'h2);
    check("two_stat", 64'(status), 64'h6);
    ns_in = 4'b0000; cw_in = 37'h0800000123; status_in = 4'b1001; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("stl_cw", 64'(controlWord), 64'h0);
      tick();
      check("stl_state", 64'(state), 64'h2);
      check("stl_cnt",   64'(instr_count), 64'h1);
      check("stl_stat",  64'(status), 64'h6);
    end
    stall = 1'b0; #1;
    check("unstl_cw", 64'(controlWord), 64'h0800000123);
    tick();
    check("ret2_state", 64'(state), 64'h0);
    check("ret2_cnt",   64'(instr_count), 64'h2);
    check("ret2_stat",  64'(status), 64'h9);

    // Stall blocks capture in FETCH
    stall = 1'b1; instr_valid = 1'b1; instr_in = 32'h0000DEAD; #1;
    check("fstl_cw",  64'(controlWord), 64'h0);
    check("fstl_req", 64'(instr_req), 64'h1);
    tick();
    check("fstl_ir",    64'(IR), 64'hA);
    check("fstl_state", 64'(state), 64'h0);
    stall = 1'b0;
    tick(); instr_valid = 1'b0;
    check("cap_ir",    64'(IR), 64'hDEAD);
    check("cap_state", 64'(state), 64'h1);

    // Illegal next state
    ns_in = 4'b0111; cw_in = '0;
    tick();
    check("ill_state", 64'(state), 64'h0);
    check("ill_fault", 64'(fault), 64'h1);
    check("ill_cnt",   64'(instr_count), 64'h2);

    // Fault persists until reset
    tick();
    check("sticky_fault", 64'(fault), 64'h1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("clr_fault", 64'(fault), 64'h0);
    check("clr_cnt",   64'(instr_count), 64'h0);

    // Retire exactly on the MAX_EX-th execute cycle is legal
    instr_in = 32'h11111111; instr_valid = 1'b1;
    tick(); instr_valid = 1'b0;
    ns_in = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("edge_state", 64'(state), 64'h3);
    end
    ns_in = 4'b0000;
    tick();
    check("edge_state_ret", 64'(state), 64'h0);
    check("edge_fault",     64'(fault), 64'h0);
    check("edge_cnt",       64'(instr_count), 64'h1);

    // Watchdog: looping EX2 forced back to fetch after the 4th EX cycle
    instr_in = 32'h22222222; instr_valid = 1'b1;
    tick(); instr_valid = 1'b0;
    ns_in = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wd_state", 64'(state), 64'h3);
      check("wd_nofault", 64'(fault), 64'h0);
    end
    tick();
    check("wd_forced", 64'(state), 64'h0);
    check("wd_fault",  64'(fault), 64'h1);
    check("wd_cnt",    64'(instr_count), 64'h1);

    // Reset mid-instruction abandons it
    ns_in = 4'b0000;
    instr_in = 32'h33333333; instr_valid = 1'b1;
    tick(); instr_valid = 1'b0;
    reset = 1'b0; #1;
    check("mid_rst_cw",  64'(controlWord), 64'h0);
    tick();
    reset = 1'b1;
    check("mid_rst_state", 64'(state), 64'h0);
    check("mid_rst_cnt",   64'(instr_count), 64'h0);
    check("mid_rst_ir",    64'(IR), 64'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
